// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage and its register file.
package wb_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] addr;
    logic                  we;
    logic                  valid;
  } wb_reg_t;

  localparam wb_reg_t WB_BUBBLE = '0;

  // Read-port priority: x0, then write-through of the committing WB result, then storage.
  function automatic logic [XLEN-1:0] bypass_read(
    input logic [REG_ADDR_W-1:0] raddr,
    input logic [XLEN-1:0]       stored,
    input logic                  wr_en,
    input logic [REG_ADDR_W-1:0] waddr,
    input logic [XLEN-1:0]       wdata
  );
    if (raddr == '0) begin
      return '0;
    end else if (wr_en && (raddr == waddr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bus, decode read ports and WB forwarding/retire outputs.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic [XLEN-1:0]       io_wRegData_MEM;
  logic [REG_ADDR_W-1:0] io_wReg_MEM;
  logic                  io_weReg_MEM;
  logic                  io_valid_MEM;
  logic                  io_stall;
  logic                  io_flush;
  logic [REG_ADDR_W-1:0] io_rs1Addr;
  logic [REG_ADDR_W-1:0] io_rs2Addr;
  logic [XLEN-1:0]       io_rs1Data;
  logic [XLEN-1:0]       io_rs2Data;
  logic [XLEN-1:0]       io_wRegData_WB;
  logic [REG_ADDR_W-1:0] io_wReg_WB;
  logic                  io_weReg_WB;
  logic                  io_valid_WB;
  logic [XLEN-1:0]       io_retireCount;

  modport master (
    output io_wRegData_MEM, io_wReg_MEM, io_weReg_MEM, io_valid_MEM,
    output io_stall, io_flush, io_rs1Addr, io_rs2Addr,
    input  io_rs1Data, io_rs2Data,
    input  io_wRegData_WB, io_wReg_WB, io_weReg_WB, io_valid_WB, io_retireCount
  );

  modport slave (
    input  io_wRegData_MEM, io_wReg_MEM, io_weReg_MEM, io_valid_MEM,
    input  io_stall, io_flush, io_rs1Addr, io_rs2Addr,
    output io_rs1Data, io_rs2Data,
    output io_wRegData_WB, io_wReg_WB, io_weReg_WB, io_valid_WB, io_retireCount
  );

endinterface

// File: rtl/wb_stage_reg_file.sv
// 32-entry register file: one write port, two raw read ports, x0 hardwired to zero.
module reg_file
  import wb_stage_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [XLEN-1:0]       rdata1_o,
  output logic [XLEN-1:0]       rdata2_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: WB pipeline register, commit, write-through read bypass, retire counter.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  wb_stage_if.slave bus
);

  wb_reg_t         wb_q, wb_d;
  logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;
  logic            commit;
  logic            rf_we;
  logic            bypass_en;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;

  // Flush beats stall so a stalled pipe can still be drained to a bubble.
  always_comb begin
    wb_d = wb_q;
    if (bus.io_flush) begin
      wb_d = WB_BUBBLE;
    end else if (!bus.io_stall) begin
      wb_d.data  = bus.io_wRegData_MEM;
      wb_d.addr  = bus.io_wReg_MEM;
      wb_d.we    = bus.io_weReg_MEM;
      wb_d.valid = bus.io_valid_MEM;
    end
  end

  assign commit       = wb_q.valid & ~bus.io_stall;
  assign rf_we        = commit & wb_q.we;
  assign retire_cnt_d = retire_cnt_q + {{(XLEN-1){1'b0}}, commit};
  // The reset edge discards the WB slot, so nothing may be forwarded during it.
  assign bypass_en    = rf_we & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q         <= WB_BUBBLE;
      retire_cnt_q <= '0;
    end else begin
      wb_q         <= wb_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  reg_file u_reg_file (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (rf_we),
    .waddr_i  (wb_q.addr),
    .wdata_i  (wb_q.data),
    .raddr1_i (bus.io_rs1Addr),
    .raddr2_i (bus.io_rs2Addr),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  assign bus.io_rs1Data = bypass_read(bus.io_rs1Addr, rf_rdata1, bypass_en, wb_q.addr, wb_q.data);
  assign bus.io_rs2Data = bypass_read(bus.io_rs2Addr, rf_rdata2, bypass_en, wb_q.addr, wb_q.data);

  assign bus.io_wRegData_WB = wb_q.data;
  assign bus.io_wReg_WB     = wb_q.addr;
  assign bus.io_weReg_WB    = wb_q.we;
  assign bus.io_valid_WB    = wb_q.valid;
  assign bus.io_retireCount = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load/bypass, x0, stall, flush, counter wrap, reset mid-stall.
module tb_wb_stage;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  wb_stage_if bus ();

  wb_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mem_drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.io_valid_MEM    = v;
    bus.io_weReg_MEM    = we;
    bus.io_wReg_MEM     = a;
    bus.io_wRegData_MEM = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    bus.io_rs1Addr = 5'd5;
    #1;
    n_cmp++;
    if (bus.io_valid_WB !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.io_valid_WB); end
    n_cmp++;
    if (bus.io_weReg_WB !== 1'b0 || bus.io_wReg_WB !== 5'd0 || bus.io_wRegData_WB !== 32'h0) begin
      n_err++; $display("FAIL reset_wbreg got we=%b addr=%0d data=%h want 0/0/0", bus.io_weReg_WB, bus.io_wReg_WB, bus.io_wRegData_WB);
    end
    n_cmp++;
    if (bus.io_retireCount !== 32'd0) begin n_err++; $display("FAIL reset_count got %h want 0", bus.io_retireCount); end
    n_cmp++;
    if (bus.io_rs1Data !== 32'h0) begin n_err++; $display("FAIL reset_x5 got %h want 0", bus.io_rs1Data); end
  endtask

  task automatic test_load_bypass();
    mem_drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    bus.io_rs1Addr = 5'd5;
    bus.io_rs2Addr = 5'd5;
    #1;
    n_cmp++;
    if (bus.io_valid_WB !== 1'b1 || bus.io_wReg_WB !== 5'd5 || bus.io_wRegData_WB !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL load_wb got v=%b addr=%0d data=%h want 1/5/deadbeef", bus.io_valid_WB, bus.io_wReg_WB, bus.io_wRegData_WB);
    end
    n_cmp++;
    if (bus.io_rs1Data !== 32'hDEADBEEF || bus.io_rs2Data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL bypass_x5 got %h/%h want deadbeef", bus.io_rs1Data, bus.io_rs2Data);
    end
    n_cmp++;
    if (bus.io_retireCount !== 32'd0) begin n_err++; $display("FAIL load_count_pre got %h want 0", bus.io_retireCount); end
    step();
    n_cmp++;
    if (bus.io_rs1Data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rf_x5 got %h want deadbeef", bus.io_rs1Data); end
    n_cmp++;
    if (bus.io_retireCount !== 32'd1) begin n_err++; $display("FAIL load_count got %h want 1", bus.io_retireCount); end
    n_cmp++;
    if (bus.io_valid_WB !== 1'b0) begin n_err++; $display("FAIL load_bubble got %b want 0", bus.io_valid_WB); end
  endtask

  task automatic test_x0_write();
    bus.io_rs1Addr = 5'd0;
    mem_drive(1'b1, 1'b1, 5'd0, 32'h12345678);
    step();
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bus.io_rs1Data !== 32'h0) begin n_err++; $display("FAIL x0_read cyc%0d got %h want 0", i, bus.io_rs1Data); end
      step();
    end
    n_cmp++;
    if (bus.io_retireCount !== 32'd2) begin n_err++; $display("FAIL x0_count got %h want 2", bus.io_retireCount); end
  endtask

  task automatic test_stall_hold();
    mem_drive(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5);
    step();
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    bus.io_stall   = 1'b1;
    bus.io_rs1Addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.io_valid_WB !== 1'b1 || bus.io_wReg_WB !== 5'd7 || bus.io_wRegData_WB !== 32'hA5A5A5A5) begin
        n_err++; $display("FAIL stall_hold cyc%0d got v=%b addr=%0d data=%h want 1/7/a5a5a5a5", i, bus.io_valid_WB, bus.io_wReg_WB, bus.io_wRegData_WB);
      end
      n_cmp++;
      if (bus.io_rs1Data !== 32'h0) begin n_err++; $display("FAIL stall_bypass cyc%0d got %h want 0", i, bus.io_rs1Data); end
      n_cmp++;
      if (bus.io_retireCount !== 32'd2) begin n_err++; $display("FAIL stall_count cyc%0d got %h want 2", i, bus.io_retireCount); end
      step();
    end
    bus.io_stall = 1'b0;
    #1;
    n_cmp++;
    if (bus.io_rs1Data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL release_bypass got %h want a5a5a5a5", bus.io_rs1Data); end
    step();
    n_cmp++;
    if (bus.io_retireCount !== 32'd3) begin n_err++; $display("FAIL release_count got %h want 3", bus.io_retireCount); end
    n_cmp++;
    if (bus.io_rs1Data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL release_x7 got %h want a5a5a5a5", bus.io_rs1Data); end
    step();
    n_cmp++;
    if (bus.io_retireCount !== 32'd3) begin n_err++; $display("FAIL release_once got %h want 3", bus.io_retireCount); end
  endtask

  task automatic test_flush();
    mem_drive(1'b1, 1'b1, 5'd3, 32'h11);
    step();
    mem_drive(1'b1, 1'b1, 5'd4, 32'h22);
    bus.io_flush   = 1'b1;
    bus.io_rs1Addr = 5'd3;
    bus.io_rs2Addr = 5'd4;
    step();
    bus.io_flush = 1'b0;
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_cmp++;
    if (bus.io_valid_WB !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.io_valid_WB); end
    n_cmp++;
    if (bus.io_rs1Data !== 32'h11) begin n_err++; $display("FAIL flush_x3 got %h want 11", bus.io_rs1Data); end
    n_cmp++;
    if (bus.io_rs2Data !== 32'h0) begin n_err++; $display("FAIL flush_x4 got %h want 0", bus.io_rs2Data); end
    n_cmp++;
    if (bus.io_retireCount !== 32'd4) begin n_err++; $display("FAIL flush_count got %h want 4", bus.io_retireCount); end
    // Flush together with stall: bubble wins, the stalled WB slot never commits.
    mem_drive(1'b1, 1'b1, 5'd6, 32'h66);
    step();
    mem_drive(1'b1, 1'b1, 5'd8, 32'h88);
    bus.io_stall   = 1'b1;
    bus.io_flush   = 1'b1;
    bus.io_rs1Addr = 5'd6;
    bus.io_rs2Addr = 5'd8;
    step();
    bus.io_stall = 1'b0;
    bus.io_flush = 1'b0;
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_cmp++;
    if (bus.io_valid_WB !== 1'b0 || bus.io_weReg_WB !== 1'b0 || bus.io_wReg_WB !== 5'd0 || bus.io_wRegData_WB !== 32'h0) begin
      n_err++; $display("FAIL flushstall_bubble got v=%b we=%b addr=%0d data=%h want 0/0/0/0", bus.io_valid_WB, bus.io_weReg_WB, bus.io_wReg_WB, bus.io_wRegData_WB);
    end
    n_cmp++;
    if (bus.io_rs1Data !== 32'h0 || bus.io_rs2Data !== 32'h0) begin
      n_err++; $display("FAIL flushstall_regs got x6=%h x8=%h want 0/0", bus.io_rs1Data, bus.io_rs2Data);
    end
    n_cmp++;
    if (bus.io_retireCount !== 32'd4) begin n_err++; $display("FAIL flushstall_count got %h want 4", bus.io_retireCount); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [31:0] exp_cnt [4];
    exp_cnt[0] = 32'hFFFFFFFE;
    exp_cnt[1] = 32'hFFFFFFFF;
    exp_cnt[2] = 32'h00000000;
    exp_cnt[3] = 32'h00000001;
    force dut.retire_cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.retire_cnt_q;
    #1;
    n_cmp++;
    if (bus.io_retireCount !== 32'hFFFFFFFE) begin n_err++; $display("FAIL wrap_preload got %h want fffffffe", bus.io_retireCount); end
    bus.io_rs1Addr = 5'd10;
    mem_drive(1'b1, 1'b0, 5'd10, 32'hCAFE0000);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
      step();
      n_cmp++;
      if (bus.io_retireCount !== exp_cnt[i]) begin n_err++; $display("FAIL wrap_count edge%0d got %h want %h", i, bus.io_retireCount, exp_cnt[i]); end
    end
    n_cmp++;
    if (bus.io_rs1Data !== 32'h0) begin n_err++; $display("FAIL wrap_we0_x10 got %h want 0", bus.io_rs1Data); end
  endtask

  task automatic test_reset_mid_stall();
    mem_drive(1'b1, 1'b1, 5'd9, 32'h55);
    step();
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    bus.io_stall   = 1'b1;
    bus.io_rs1Addr = 5'd9;
    bus.io_rs2Addr = 5'd5;
    step();
    n_cmp++;
    if (bus.io_valid_WB !== 1'b1 || bus.io_wReg_WB !== 5'd9) begin
      n_err++; $display("FAIL midstall_held got v=%b addr=%0d want 1/9", bus.io_valid_WB, bus.io_wReg_WB);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.io_rs1Data !== 32'h0 || bus.io_rs2Data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rstcycle_read got x9=%h x5=%h want 0/deadbeef", bus.io_rs1Data, bus.io_rs2Data);
    end
    step();
    reset        = 1'b0;
    bus.io_stall = 1'b0;
    #1;
    n_cmp++;
    if (bus.io_valid_WB !== 1'b0) begin n_err++; $display("FAIL midstall_valid got %b want 0", bus.io_valid_WB); end
    n_cmp++;
    if (bus.io_retireCount !== 32'd0) begin n_err++; $display("FAIL midstall_count got %h want 0", bus.io_retireCount); end
    n_cmp++;
    if (bus.io_rs1Data !== 32'h0 || bus.io_rs2Data !== 32'h0) begin
      n_err++; $display("FAIL midstall_regs got x9=%h x5=%h want 0/0", bus.io_rs1Data, bus.io_rs2Data);
    end
    step();
    n_cmp++;
    if (bus.io_rs1Data !== 32'h0 || bus.io_retireCount !== 32'd0) begin
      n_err++; $display("FAIL midstall_after got x9=%h cnt=%h want 0/0", bus.io_rs1Data, bus.io_retireCount);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b0;
    bus.io_stall   = 1'b0;
    bus.io_flush   = 1'b0;
    bus.io_rs1Addr = 5'd0;
    bus.io_rs2Addr = 5'd0;
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_load_bypass();
    test_x0_write();
    test_stall_hold();
    test_flush();
    test_back_to_back_wrap();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
